// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back, write-allocate data cache for the
// MEM stage, with line write-back and refill against off-chip data memory.
module dcache_ctrl #(
   parameter int NUM_LINES = 16,
   parameter int LINE_BITS = 256,
   parameter int ADDR_W    = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - 5 - IDX_W;

   typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;
   state_t state, stateNext;

   logic [LINE_BITS-1:0] dataArr [NUM_LINES];
   logic [TAG_W-1:0]     tagArr  [NUM_LINES];
   logic [NUM_LINES-1:0] validArr, dirtyArr;
   logic [ADDR_W-6:0]    missLine;

   logic [IDX_W-1:0] cpuIdx, missIdx;
   logic [TAG_W-1:0] cpuTag, missTag;
   logic [2:0]       wordSel;
   logic             hit, storeHit, missStart, refillDone;
   logic             unusedBits;

   assign cpuIdx     = cpu_addr_i[5 +: IDX_W];
   assign cpuTag     = cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign wordSel    = cpu_addr_i[4:2];
   assign unusedBits = ^cpu_addr_i[1:0];
   assign missIdx    = missLine[IDX_W-1:0];
   assign missTag    = missLine[ADDR_W-6 -: TAG_W];
   assign hit        = validArr[cpuIdx] && (tagArr[cpuIdx] == cpuTag);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         validArr <= '0;
         dirtyArr <= '0;
         missLine <= '0;
      end else begin
         state <= stateNext;
         if (missStart) missLine <= cpu_addr_i[ADDR_W-1:5];
         if (storeHit) dirtyArr[cpuIdx] <= 1'b1;
         if (refillDone) begin
            validArr[missIdx] <= 1'b1;
            dirtyArr[missIdx] <= 1'b0;
         end
      end
   end

   // Array contents need no reset; valid bits gate every use.
   always_ff @(posedge clk_i) begin
      if (storeHit)
         dataArr[cpuIdx][{wordSel, 5'b0} +: 32] <= cpu_data_i;
      if (refillDone) begin
         dataArr[missIdx] <= mem_data_i;
         tagArr[missIdx]  <= missTag;
      end
   end

   always_comb begin
      stateNext   = state;
      cpu_stall_o = 1'b0;
      cpu_data_o  = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_data_o  = '0;
      storeHit    = 1'b0;
      missStart   = 1'b0;
      refillDone  = 1'b0;
      unique case (state)
         IDLE: begin
            if (cpu_req_i) begin
               if (hit) begin
                  if (cpu_we_i) storeHit = 1'b1;
                  else cpu_data_o = dataArr[cpuIdx][{wordSel, 5'b0} +: 32];
               end else begin
                  cpu_stall_o = 1'b1;
                  missStart   = 1'b1;
                  stateNext   = (validArr[cpuIdx] && dirtyArr[cpuIdx])
                                ? WB : REFILL;
               end
            end
         end
         WB: begin
            cpu_stall_o = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {tagArr[missIdx], missIdx, 5'b0};
            mem_data_o  = dataArr[missIdx];
            if (mem_ack_i) stateNext = REFILL;
         end
         REFILL: begin
            cpu_stall_o = 1'b1;
            mem_req_o   = 1'b1;
            mem_addr_o  = {missLine, 5'b0};
            if (mem_ack_i) begin
               refillDone = 1'b1;
               stateNext  = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
      // Outputs collapse to zero the instant reset asserts.
      if (!rst_i) begin
         cpu_stall_o = 1'b0;
         cpu_data_o  = '0;
         mem_req_o   = 1'b0;
         mem_we_o    = 1'b0;
         mem_addr_o  = '0;
         mem_data_o  = '0;
         storeHit    = 1'b0;
         missStart   = 1'b0;
         refillDone  = 1'b0;
      end
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and randomized checks of dcache_ctrl against a
// flat-memory view plus a resident-line map of the direct-mapped cache.
module tb_dcache_ctrl;
   logic         clk, rstN;
   logic         cpuReq, cpuWe;
   logic [31:0]  cpuAddr, cpuDin, cpuDout;
   logic         stall, memReq, memWe, memAck;
   logic [31:0]  memAddr;
   logic [255:0] memDout, memDin;

   dcache_ctrl dut (
      .clk_i(clk), .rst_i(rstN),
      .cpu_req_i(cpuReq), .cpu_we_i(cpuWe), .cpu_addr_i(cpuAddr),
      .cpu_data_i(cpuDin), .cpu_data_o(cpuDout), .cpu_stall_o(stall),
      .mem_req_o(memReq), .mem_we_o(memWe), .mem_addr_o(memAddr),
      .mem_data_o(memDout), .mem_data_i(memDin), .mem_ack_i(memAck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // flatMem: architectural truth; extMem: what off-chip memory holds
   logic [255:0] flatMem [256];
   logic [255:0] extMem  [256];
   int           resLine  [16];
   bit           resValid [16];
   bit           resDirty [16];

   task automatic chk(input string tag, input logic [255:0] got,
                      input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic serveMem(input bit expWe, input logic [31:0] expAddr,
                           input logic [255:0] expData, input int lat);
      int n;
      logic [31:0]  a;
      logic [255:0] d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!memReq && n < 6);
      chk("memReq", memReq, 1);
      if (!memReq) return;
      chk("memWe", memWe, expWe);
      chk("memAddr", memAddr, expAddr);
      if (expWe) chk("wbData", memDout, expData);
      chk("xferStall", stall, 1);
      a = memAddr;
      d = memDout;
      repeat (lat) begin
         @(negedge clk);
         chk("holdReq", memReq, 1);
         chk("holdAddr", memAddr, a);
         chk("holdData", memDout, d);
         chk("holdStall", stall, 1);
      end
      memAck = 1'b1;
      if (!expWe) memDin = extMem[expAddr[12:5]];
      @(posedge clk);
      #1;
      memAck = 1'b0;
      if (expWe) extMem[expAddr[12:5]] = d;
   endtask

   task automatic doAccess(input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, input int lat);
      int ln, ix, wi;
      bit expHit;
      logic [31:0] la;
      ln = int'(addr[12:5]);
      ix = int'(addr[8:5]);
      wi = int'(addr[4:2]);
      expHit = resValid[ix] && resLine[ix] == ln;
      cpuReq = 1'b1;
      cpuWe = we;
      cpuAddr = addr;
      cpuDin = wd;
      @(negedge clk);
      if (!expHit) begin
         chk("missStall", stall, 1);
         chk("missNoReq", memReq, 0);
         if (resValid[ix] && resDirty[ix]) begin
            la = 32'(resLine[ix]) << 5;
            serveMem(1'b1, la, flatMem[resLine[ix]], lat);
         end
         la = 32'(ln) << 5;
         serveMem(1'b0, la, '0, lat);
         @(negedge clk);
      end
      chk("hitStall", stall, 0);
      if (!we) chk("loadData", cpuDout, flatMem[ln][wi*32 +: 32]);
      @(posedge clk);
      #1;
      cpuReq = 1'b0;
      cpuWe = 1'b0;
      resValid[ix] = 1'b1;
      resLine[ix] = ln;
      if (!expHit) resDirty[ix] = 1'b0;
      if (we) begin
         flatMem[ln][wi*32 +: 32] = wd;
         resDirty[ix] = 1'b1;
      end
   endtask

   initial begin
      logic [31:0] ra;
      rstN = 1'b0;
      cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuDin = '0;
      memAck = 1'b0; memDin = '0;
      for (int i = 0; i < 256; i++) begin
         for (int w = 0; w < 8; w++) extMem[i][w*32 +: 32] = $urandom;
      end
      extMem[2][95:64] = 32'hDEAD_BEEF;
      for (int i = 0; i < 256; i++) flatMem[i] = extMem[i];
      for (int i = 0; i < 16; i++) begin
         resValid[i] = 0; resDirty[i] = 0; resLine[i] = 0;
      end

      @(posedge clk);
      #1;
      chk("rstStall", stall, 0);
      chk("rstReq", memReq, 0);
      chk("rstData", cpuDout, 0);
      rstN = 1'b1;
      @(negedge clk);
      chk("idleStall", stall, 0);
      chk("idleReq", memReq, 0);
      chk("idleData", cpuDout, 0);
      @(posedge clk);
      #1;

      doAccess(0, 32'h40, 0, 1);
      doAccess(0, 32'h48, 0, 0);
      chk("t1word2", flatMem[2][95:64], 32'hDEAD_BEEF);

      doAccess(1, 32'h44, 32'h1234_5678, 0);
      memAck = 1'b1;
      memDin = {8{32'hFFFF_FFFF}};
      @(posedge clk);
      #1;
      memAck = 1'b0;
      doAccess(0, 32'h44, 0, 0);

      doAccess(0, 32'h240, 0, 2);
      chk("t3wbWord1", extMem[2][63:32], 32'h1234_5678);

      doAccess(0, 32'h400, 0, 10);

      cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h260;
      @(negedge clk);
      chk("t5missStall", stall, 1);
      @(negedge clk);
      chk("t5refillReq", memReq, 1);
      chk("t5refillWe", memWe, 0);
      #2 rstN = 1'b0;
      #1;
      chk("t5rstReq", memReq, 0);
      chk("t5rstStall", stall, 0);
      cpuReq = 1'b0;
      @(posedge clk);
      #1;
      rstN = 1'b1;
      for (int i = 0; i < 16; i++) begin
         resValid[i] = 0; resDirty[i] = 0;
      end
      for (int i = 0; i < 256; i++) flatMem[i] = extMem[i];
      doAccess(0, 32'h240, 0, 1);

      doAccess(1, 32'h80, 32'hCAFE_0001, 1);
      doAccess(0, 32'h80, 0, 0);
      doAccess(0, 32'h280, 0, 1);
      chk("t6wbWord0", extMem[4][31:0], 32'hCAFE_0001);

      for (int k = 0; k < 300; k++) begin
         ra = {19'b0, 6'($urandom_range(0, 63)), 3'($urandom), 2'($urandom)};
         doAccess(bit'($urandom_range(0, 1)), ra, $urandom,
                  $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
